// File: rtl/ssbcc_uart_tx.sv
// UART transmit outport peripheral: a byte FIFO fed by the core's outport strobe, serialised 8N1/8N2.
// Define SSBCC_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module ssbcc_uart_tx #(
  parameter int unsigned BAUD_DIV        = 868,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned STOP_BITS       = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_outport_data,
  input  logic       i_outport_wr,
  output logic       o_uart_tx,
  output logic       o_fifo_full,
  output logic       o_fifo_empty,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int unsigned AW        = FIFO_DEPTH_LOG2;
  localparam int unsigned PW        = AW + 1;
  localparam int unsigned DEPTH     = 1 << AW;
  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SSBCC_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [7:0]    head;
  logic [7:0]    shreg;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_cnt;
  logic          push, pop, baud_zero, stop_done;
`ifdef SSBCC_UART_TX_PARITY_EN
  logic          parity;
`endif

  assign head   = mem[rd_ptr[AW-1:0]];
  assign o_busy = ~o_fifo_empty | (state != IDLE);

  // A frame is fetched from IDLE or straight out of the final stop bit.
  always_comb begin
    push      = i_outport_wr & ~o_fifo_full;
    baud_zero = (baud_cnt == 16'd0);
    stop_done = (state == STOP) & baud_zero & (bit_cnt == STOP_LAST);
    pop       = ~o_fifo_empty & ((state == IDLE) | stop_done);
    wr_ptr_n  = wr_ptr + PW'(push);
    rd_ptr_n  = rd_ptr + PW'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_outport_data;
  end

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_empty <= 1'b1;
      o_fifo_full  <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      o_fifo_empty <= (wr_ptr_n == rd_ptr_n);
      o_fifo_full  <= ((wr_ptr_n ^ rd_ptr_n) == FULL_XOR);
      if (i_outport_wr & o_fifo_full) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_uart_tx <= 1'b1;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
`ifdef SSBCC_UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg     <= head;
`ifdef SSBCC_UART_TX_PARITY_EN
            parity    <= ^head;
`endif
            o_uart_tx <= 1'b0;
            baud_cnt  <= BAUD_LOAD;
            state     <= START;
          end
        end
        START: begin
          if (baud_zero) begin
            o_uart_tx <= shreg[0];
            shreg     <= {1'b0, shreg[7:1]};
            bit_cnt   <= 3'd0;
            baud_cnt  <= BAUD_LOAD;
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (baud_zero) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_cnt == 3'd7) begin
`ifdef SSBCC_UART_TX_PARITY_EN
              o_uart_tx <= parity;
              state     <= PARITY;
`else
              o_uart_tx <= 1'b1;
              bit_cnt   <= 3'd0;
              state     <= STOP;
`endif
            end else begin
              o_uart_tx <= shreg[0];
              shreg     <= {1'b0, shreg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`ifdef SSBCC_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_zero) begin
            o_uart_tx <= 1'b1;
            bit_cnt   <= 3'd0;
            baud_cnt  <= BAUD_LOAD;
            state     <= STOP;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          if (baud_zero) begin
            if (bit_cnt == STOP_LAST) begin
              // Back-to-back: the next start bit follows the last stop bit directly.
              if (pop) begin
                shreg     <= head;
`ifdef SSBCC_UART_TX_PARITY_EN
                parity    <= ^head;
`endif
                o_uart_tx <= 1'b0;
                baud_cnt  <= BAUD_LOAD;
                state     <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              baud_cnt <= BAUD_LOAD;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssbcc_uart_tx.sv
// Bench for ssbcc_uart_tx: directed and random writes checked every cycle against a frame-level model.
module tb_ssbcc_uart_tx;

  localparam int unsigned BAUD  = 4;
  localparam int unsigned DL2   = 2;
  localparam int unsigned SB    = 1;
  localparam int unsigned DEPTH = 1 << DL2;
`ifdef SSBCC_UART_TX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FL = (9 + PB + SB) * BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'd0;
  logic       tx, full, empty, busy, ovf;

  always #5 clk = ~clk;

  ssbcc_uart_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH_LOG2(DL2), .STOP_BITS(SB)) dut (
    .i_clk(clk), .i_rst(rst), .i_outport_data(din), .i_outport_wr(wr),
    .o_uart_tx(tx), .o_fifo_full(full), .o_fifo_empty(empty),
    .o_busy(busy), .o_overflow(ovf)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: queue of stored bytes, byte on the line and cycle offset into its frame.
  logic [7:0] mq[$];
  logic [7:0] cur = 8'd0;
  int         pos = 0;
  bit         line_idle = 1'b1;
  bit         m_ovf = 1'b0;

  // Frame bit index: 0 start, 1..8 data LSB first, optional parity, then stop bits.
  function automatic logic fbit(input logic [7:0] b, input int idx);
    logic [7:0] v;
    v = b;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[idx-1];
    if (PB == 1 && idx == 9) return ^v;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit w, input logic [7:0] d);
    bit pre_full;
    if (r) begin
      mq.delete();
      line_idle = 1'b1;
      m_ovf     = 1'b0;
      pos       = 0;
      return;
    end
    pre_full = (mq.size() == DEPTH);
    if (!line_idle) begin
      pos++;
      if (pos == FL) line_idle = 1'b1;
    end
    if (line_idle && mq.size() > 0) begin
      cur       = mq.pop_front();
      pos       = 0;
      line_idle = 1'b0;
    end
    if (w) begin
      if (pre_full) m_ovf = 1'b1;
      else mq.push_back(d);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, check all outputs just after it.
  task automatic cyc(input bit r, input bit w, input logic [7:0] d);
    rst = r;
    wr  = w;
    din = d;
    @(posedge clk);
    model_edge(r, w, d);
    #1;
    chk("uart_tx", tx, line_idle ? 1'b1 : fbit(cur, pos / BAUD));
    chk("fifo_empty", empty, mq.size() == 0);
    chk("fifo_full", full, mq.size() == DEPTH);
    chk("busy", busy, !line_idle || mq.size() != 0);
    chk("overflow", ovf, m_ovf);
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while (!(line_idle && mq.size() == 0) && n < max) begin
      cyc(1'b0, 1'b0, 8'd0);
      n++;
    end
    n_assert++;
    assert (line_idle && mq.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d cycles expected idle within %0d", n, max);
    end
    cyc(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    // Reset held for five cycles, then released.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'd0);

    // Single byte.
    cyc(1'b0, 1'b1, 8'hA5);
    run_idle(200);

    // Back-to-back frames.
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'hFF);
    run_idle(300);

    // Fill past capacity while the line is busy: 06 is dropped.
    for (int i = 1; i <= 6; i++) cyc(1'b0, 1'b1, 8'(i));
    run_idle(600);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);

    // Continuous writes, including writes to a full FIFO on a pop edge.
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 8'(8'hC0 + i));
    run_idle(1000);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);

    // Reset during data bit 3, then a fresh frame.
    cyc(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 100 && !(!line_idle && pos == 4 * BAUD + 1); i++)
      cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'h81);
    run_idle(200);

    // Odd-weight byte (parity bit 1 when enabled).
    cyc(1'b0, 1'b1, 8'h07);
    run_idle(200);

    // Random traffic with occasional bursts.
    for (int i = 0; i < 1500; i++)
      cyc(1'b0, $urandom_range(0, 24) == 0, 8'($urandom));
    for (int i = 0; i < 300; i++)
      cyc(1'b0, $urandom_range(0, 3) == 0, 8'($urandom));
    run_idle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
